// File: rtl/mat_vec_sched.sv
// mat_vec_sched: feeds 4x4 matrix-vector jobs to an external multiplier and buffers results in a credit-guarded FIFO.
// Optional MAT_VEC_SCHED_STATS_EN adds stat_issued / stat_stall counters.
module mat_vec_sched #(
  parameter int DATAWIDTH   = 24,
  parameter int FRACBITS    = 13,
  parameter int MUL_LATENCY = 5,
  parameter int OUT_DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               mat_load,
  input  logic [3:0][3:0][DATAWIDTH-1:0]     mat_in,
  output logic                               mat_ack,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [3:0][DATAWIDTH-1:0]          s_x,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [3:0][DATAWIDTH-1:0]          m_y,
  output logic [3:0][3:0][DATAWIDTH-1:0]     mul_A,
  output logic [3:0][DATAWIDTH-1:0]          mul_x,
  output logic                               mul_dv,
  input  logic [3:0][DATAWIDTH-1:0]          mul_y,
  input  logic                               mul_dv_out,
  output logic                               busy
`ifdef MAT_VEC_SCHED_STATS_EN
  ,
  output logic [31:0]                        stat_issued,
  output logic [31:0]                        stat_stall
`endif
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MUL_LATENCY + 1);
  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 || FRACBITS >= DATAWIDTH) begin : g_bad_param
    $error("mat_vec_sched: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [3:0][3:0][DATAWIDTH-1:0] mat_act, mat_pend;
  logic [3:0][DATAWIDTH-1:0] mem [OUT_DEPTH];
  logic [CW-1:0] inflight, fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] ign;
  logic load_ok, load_now, load_defer, issue, ret, pop, swap, go_idle;
  // mat_ack blocks a still-held mat_load from being taken a second time
  assign load_ok    = mat_load && !mat_ack && state != DRAIN;
  assign load_now   = load_ok && (state == IDLE || inflight == '0);
  assign load_defer = load_ok && !load_now;
  assign ret        = mul_dv_out && ign == '0 && inflight != '0;
  assign s_ready    = state != DRAIN && !load_ok &&
                      ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(OUT_DEPTH);
  assign issue      = s_valid && s_ready;
  assign m_valid    = fifo_count != '0;
  assign pop        = m_valid && m_ready;
  assign swap       = state == DRAIN && inflight == CW'(ret);
  assign go_idle    = inflight == '0 && fifo_count == '0 && !s_valid;
  assign m_y        = m_valid ? mem[rd_ptr] : '0;
  assign mul_A      = mat_act;
  assign busy       = state != IDLE || inflight != '0 || fifo_count != '0;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (issue ? RUN : IDLE) :
               state == RUN  ? (load_defer ? DRAIN : (go_idle ? IDLE : RUN)) :
                               (swap ? RUN : DRAIN);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      mat_act    <= '0;
      mat_pend   <= '0;
      mat_ack    <= 1'b0;
      mul_dv     <= 1'b0;
      mul_x      <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ign        <= LW'(MUL_LATENCY);
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_nx;
      mat_ack    <= load_now || swap;
      mul_dv     <= issue;
      inflight   <= inflight + CW'(issue) - CW'(ret);
      fifo_count <= fifo_count + CW'(ret) - CW'(pop);
      if (load_now) mat_act <= mat_in;
      else if (swap) mat_act <= mat_pend;
      if (load_defer) mat_pend <= mat_in;
      if (issue) mul_x <= s_x;
      if (ret) begin
        mem[wr_ptr] <= mul_y;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ign != '0) ign <= ign - 1'b1;
    end
  end
`ifdef MAT_VEC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      stat_issued <= stat_issued + 32'(issue);
      stat_stall  <= stat_stall + 32'(s_valid && !s_ready);
    end
  end
`endif
endmodule

// File: tb/tb_mat_vec_sched.sv
// tb_mat_vec_sched: directed scoreboard bench for mat_vec_sched with a behavioural 5-cycle multiplier.
module tb_mat_vec_sched;
  localparam int DW  = 24;
  localparam int LAT = 5;
  typedef logic [3:0][DW-1:0] vec_t;
  typedef logic [3:0][3:0][DW-1:0] mat_t;
  logic clk = 0, rstn = 0, mat_load = 0, s_valid = 0, m_ready = 1;
  logic mat_ack, s_ready, m_valid, mul_dv, mul_dv_out, busy;
  mat_t mat_in = '0, mul_a;
  vec_t s_x = '0, m_y, mul_x, mul_y;
`ifdef MAT_VEC_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif
  int cyc = 0, checks = 0, errors = 0, m_checks = 0, m_errors = 0;
  int rise_cyc = -1, acc_cyc = 0;
  int pop_cyc[$];
  vec_t q[$];
  bit pipe_v[LAT];
  vec_t pipe_y[LAT];
  vec_t e, prev_y;
  bit prev_hold = 0, prev_mv = 0;

  mat_vec_sched dut (
    .clk(clk), .rstn(rstn), .mat_load(mat_load), .mat_in(mat_in), .mat_ack(mat_ack),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y),
    .mul_A(mul_a), .mul_x(mul_x), .mul_dv(mul_dv), .mul_y(mul_y), .mul_dv_out(mul_dv_out),
    .busy(busy)
`ifdef MAT_VEC_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t matmul(input mat_t a, input vec_t x);
    longint acc;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int j = 0; j < 4; j++) acc += longint'($signed(a[i][j])) * longint'($signed(x[j]));
      matmul[i] = DW'(acc >>> 13);
    end
  endfunction

  // external multiplier: not reset by rstn, so stale returns can arrive after reset
  always @(posedge clk) begin
    pipe_v[0] <= mul_dv;
    pipe_y[0] <= matmul(mul_a, mul_x);
    for (int k = 1; k < LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_y[k] <= pipe_y[k-1];
    end
  end
  assign mul_dv_out = pipe_v[LAT-1];
  assign mul_y      = pipe_y[LAT-1];

  function automatic vec_t fx4(input int a, input int b, input int c, input int d);
    fx4[0] = DW'(a * 8192);
    fx4[1] = DW'(b * 8192);
    fx4[2] = DW'(c * 8192);
    fx4[3] = DW'(d * 8192);
  endfunction

  function automatic mat_t diag(input int v);
    diag = '0;
    for (int i = 0; i < 4; i++) diag[i][i] = DW'(v);
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (!rstn) begin
      prev_hold = 0;
      prev_mv   = 0;
    end else begin
      if (prev_hold) begin
        m_checks++;
        if (m_y !== prev_y) begin
          m_errors++;
          $display("FAIL hold_stable: m_y %h changed from %h", m_y, prev_y);
        end
      end
      if (m_valid && !prev_mv) rise_cyc = cyc;
      if (m_valid && m_ready) begin
        m_checks++;
        pop_cyc.push_back(cyc);
        if (q.size() == 0) begin
          m_errors++;
          $display("FAIL unexpected_result: got %h with nothing expected", m_y);
        end else begin
          e = q.pop_front();
          if (m_y !== e) begin
            m_errors++;
            $display("FAIL result: got %h expected %h", m_y, e);
          end
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_y    = m_y;
      prev_mv   = m_valid;
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic send(input vec_t x, input vec_t ex, output int waits);
    waits = 0;
    s_valid = 1;
    s_x = x;
    #1;
    while (!s_ready && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (s_ready) begin
      q.push_back(ex);
      acc_cyc = cyc + 1;
    end else check("send_timeout", 0, 1);
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic load(input mat_t m, output int n, output int lo);
    mat_load = 1;
    mat_in = m;
    n = 0;
    lo = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (!mat_ack && !s_ready) lo++;
    end while (!mat_ack && n < 50);
    mat_load = 0;
    check("ack_seen", mat_ack, 1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    rstn = 0;
    q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    int n, lo, w, idx, stall, seen, pc0;
    vec_t vecs[12];
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_y_nz", m_y != '0, 0);
    check("rst_mul_dv", mul_dv, 0);
    check("rst_mul_x_nz", mul_x != '0, 0);
    check("rst_mul_a_nz", mul_a != '0, 0);
    check("rst_mat_ack", mat_ack, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rstn = 1;
    // identity load then single vector latency
    load(diag(32'h2000), n, lo);
    check("ack_delay", n, 1);
    rise_cyc = -1;
    send(fx4(1, 2, 3, 4), fx4(1, 2, 3, 4), w);
    wait_empty();
    check("latency", rise_cyc - acc_cyc, 6);
    // matrix swap with vectors in flight
    send(fx4(1, 2, 3, 4), fx4(1, 2, 3, 4), w);
    send(fx4(5, -6, 7, 0), fx4(5, -6, 7, 0), w);
    send(fx4(-1, 8, -2, 3), fx4(-1, 8, -2, 3), w);
    load(diag(32'h4000), n, lo);
    check("drain_stall_cycles", lo, 5);
    check("drain_ack_delay", n, 6);
    send(fx4(1, 2, 3, 4), fx4(2, 4, 6, 8), w);
    send(fx4(-3, 5, 0, 7), fx4(-6, 10, 0, 14), w);
    wait_empty();
    // backpressure: fill credits, then release
    do_reset();
    load(diag(32'h2000), n, lo);
    for (int i = 0; i < 12; i++) vecs[i] = fx4(i, i + 1, -i, 2 * i + 3);
    m_ready = 0;
    idx = 0;
    stall = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1;
      s_x = vecs[idx];
      #1;
      if (s_ready) begin
        q.push_back(vecs[idx]);
        idx++;
      end else stall++;
      @(negedge clk);
    end
    check("accepted_while_blocked", idx, 8);
    #1;
    check("s_ready_when_full", s_ready, 0);
    m_ready = 1;
    for (int c = 0; c < 200 && idx < 12; c++) begin
      s_valid = 1;
      s_x = vecs[idx];
      #1;
      if (s_ready) begin
        q.push_back(vecs[idx]);
        idx++;
      end else stall++;
      @(negedge clk);
    end
    s_valid = 0;
    check("accepted_total", idx, 12);
    wait_empty();
`ifdef MAT_VEC_SCHED_STATS_EN
    check("stat_issued", stat_issued, 12);
    check("stat_stall", stat_stall, stall);
`endif
    // continuous streaming
    pc0 = pop_cyc.size();
    stall = 0;
    for (int i = 0; i < 20; i++) begin
      send(fx4(i, -i, 2 * i, 1), fx4(i, -i, 2 * i, 1), w);
      stall += w;
    end
    check("stream_no_stall", stall, 0);
    wait_empty();
    check("stream_pops", pop_cyc.size() - pc0, 20);
    if (pop_cyc.size() >= pc0 + 20) check("stream_one_per_cycle", pop_cyc[pc0 + 19] - pop_cyc[pc0], 19);
    // reset with work in flight and buffered
    m_ready = 0;
    for (int i = 0; i < 7; i++) send(fx4(i, 1, 1, 1), fx4(i, 1, 1, 1), w);
    repeat (2) @(negedge clk);
    #1;
    check("busy_before_reset", busy, 1);
    check("m_valid_before_reset", m_valid, 1);
    rstn = 0;
    q.delete();
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_y_nz", m_y != '0, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    m_ready = 1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (m_valid) seen++;
    end
    check("no_results_after_reset", seen, 0);
    check("busy_after_reset", busy, 0);
    checks += m_checks;
    errors += m_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
